decode_stage_0: RTL and testbench

- First decode stage: parses raw instruction bytes from the fetch window into the stage-0 pipe consumed by decode stage 1.
- Per instruction it finds prefixes, opcode, ModRM/SIB, displacement and immediate, and sets ROM-sequencer control.
- It holds the fields in an output register with a valid/ready handshake, tells fetch how many bytes it consumed, and tracks the PC of each instruction.

---
 rtl/decode_stage_0.sv | 228 ++++++++++++++++++++++
 tb/tb_decode_stage_0.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_0.sv
// First decode stage: parses prefixes, opcode, ModRM/SIB, displacement and
// immediate from the fetch window into the registered stage-0 pipe.
module decode_stage_0 #(
    parameter int unsigned       IADDRW   = 32,
    parameter logic [IADDRW-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              write_eip,
    input  logic [31:0]       eip,
    input  logic              fetch_valid,
    input  logic [127:0]      fetch_bytes,
    input  logic [4:0]        fetch_count,
    input  logic              fetch_branch_taken,
    output logic              fetch_consume,
    output logic [3:0]        fetch_consume_len,
    output logic              halted,
    output logic              s0_valid,
    input  logic              s0_ready,
    output logic [63:0]       s0_displace_n_imm,
    output logic [15:0]       s0_addressing,
    output logic [1:0]        s0_addressing_bytes,
    output logic [3:0]        s0_displacement_bytes,
    output logic [15:0]       s0_opcode,
    output logic [1:0]        s0_opcode_bytes,
    output logic [3:0]        s0_immediete_bytes,
    output logic [23:0]       s0_prefix,
    output logic [1:0]        s0_prefix_bytes,
    output logic [3:0]        s0_rom_control,
    output logic              s0_rom_in_control,
    output logic [IADDRW-1:0] s0_pc,
    output logic              s0_branch_taken,
    output logic              s0_size_override
);

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t            state;
    logic [IADDRW-1:0] pc;

    logic [7:0]  b0, b1, b2, op0, op1, modrm, sib;
    logic        pfx0, pfx1, pfx2, two_byte, has_modrm, has_sib, size_ovr, is_hlt;
    logic [1:0]  npfx, opb, addrb;
    logic [2:0]  disp, imm, dni_len;
    logic [3:0]  mi, ds, rom_ctl;
    logic        rom_in;
    logic [4:0]  len;
    logic [23:0] prefix;
    logic [63:0] dni;
    logic        issue;

    function automatic logic [7:0] byte_at(input logic [127:0] w, input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 16; i++)
            if (idx == 4'(i)) r = w[127-8*i -: 8];
        return r;
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return b inside {8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E,
                         8'h64, 8'h65, 8'h66, 8'h67};
    endfunction

    function automatic logic modrm_1b(input logic [7:0] op);
        return (op[7:6] == 2'b00 && !op[2]) || (op[7:4] == 4'h8) ||
               (op inside {8'h69, 8'h6B, 8'hC0, 8'hC1, 8'hC6, 8'hC7, 8'hD0, 8'hD1,
                           8'hD2, 8'hD3, 8'hF6, 8'hF7, 8'hFE, 8'hFF});
    endfunction

    function automatic logic modrm_2b(input logic [7:0] op);
        return (op[7:4] == 4'h4) || (op[7:4] == 4'h9) ||
               (op inside {8'hA3, 8'hAB, 8'hAF, 8'hB6, 8'hB7, 8'hBE, 8'hBF});
    endfunction

    // Instruction field extraction and length computation from the window
    always_comb begin
        b0   = byte_at(fetch_bytes, 4'd0);
        b1   = byte_at(fetch_bytes, 4'd1);
        b2   = byte_at(fetch_bytes, 4'd2);
        pfx0 = is_prefix(b0);
        pfx1 = pfx0 && is_prefix(b1);
        pfx2 = pfx1 && is_prefix(b2);
        npfx = pfx2 ? 2'd3 : (pfx1 ? 2'd2 : (pfx0 ? 2'd1 : 2'd0));
        prefix   = {pfx0 ? b0 : 8'h00, pfx1 ? b1 : 8'h00, pfx2 ? b2 : 8'h00};
        size_ovr = (pfx0 && b0 == 8'h66) || (pfx1 && b1 == 8'h66) || (pfx2 && b2 == 8'h66);

        op0      = byte_at(fetch_bytes, 4'(npfx));
        two_byte = (op0 == 8'h0F);
        op1      = two_byte ? byte_at(fetch_bytes, 4'(npfx) + 4'd1) : 8'h00;
        opb      = two_byte ? 2'd2 : 2'd1;
        mi       = 4'(npfx) + 4'(opb);
        modrm    = byte_at(fetch_bytes, mi);
        sib      = byte_at(fetch_bytes, mi + 4'd1);

        has_modrm = two_byte ? modrm_2b(op1) : modrm_1b(op0);
        has_sib   = has_modrm && modrm[7:6] != 2'b11 && modrm[2:0] == 3'b100;
        addrb     = has_modrm ? (has_sib ? 2'd2 : 2'd1) : 2'd0;

        // 32-bit addressing displacement
        disp = 3'd0;
        if (has_modrm) begin
            case (modrm[7:6])
                2'b00: if (modrm[2:0] == 3'b101 || (has_sib && sib[2:0] == 3'b101)) disp = 3'd4;
                2'b01: disp = 3'd1;
                2'b10: disp = 3'd4;
                default: disp = 3'd0;
            endcase
        end

        // Immediate size; Z shrinks to 2 under an operand-size prefix
        imm = 3'd0;
        if (two_byte) begin
            if (op1[7:4] == 4'h8) imm = size_ovr ? 3'd2 : 3'd4;
        end else if ((op0[7:6] == 2'b00 && op0[2:0] == 3'b100) || op0[7:4] == 4'h7 ||
                     op0[7:3] == 5'b10110 ||
                     (op0 inside {8'h6A, 8'h6B, 8'h80, 8'h83, 8'hA8, 8'hC0, 8'hC1, 8'hC6, 8'hEB}) ||
                     (op0 == 8'hF6 && modrm[5:3] == 3'b000)) begin
            imm = 3'd1;
        end else if ((op0[7:6] == 2'b00 && op0[2:0] == 3'b101) || op0[7:3] == 5'b10111 ||
                     (op0 inside {8'h68, 8'h69, 8'h81, 8'hA9, 8'hC7, 8'hE8, 8'hE9}) ||
                     (op0 == 8'hF7 && modrm[5:3] == 3'b000)) begin
            imm = size_ovr ? 3'd2 : 3'd4;
        end else if (op0 == 8'hC2 || op0 == 8'hCA) begin
            imm = 3'd2;
        end else if (op0 == 8'h9A || op0 == 8'hEA) begin
            imm = size_ovr ? 3'd4 : 3'd6;
        end

        // Displacement and immediate bytes packed left-justified
        ds      = mi + 4'(addrb);
        dni_len = disp + imm;
        dni     = 64'h0;
        for (int i = 0; i < 8; i++)
            if (3'(i) < dni_len || (i == 7 && dni_len == 3'd0 && 1'b0))
                dni[63-8*i -: 8] = byte_at(fetch_bytes, ds + 4'(i));

        len = 5'(npfx) + 5'(opb) + 5'(addrb) + 5'(disp) + 5'(imm);

        // ROM-sequenced opcodes
        rom_ctl = 4'd0;
        rom_in  = 1'b0;
        if (!two_byte) begin
            case (op0)
                8'hC3, 8'hC2: begin rom_ctl = 4'd1; rom_in = 1'b1; end
                8'hCB, 8'hCA: begin rom_ctl = 4'd2; rom_in = 1'b1; end
                8'hE8:        begin rom_ctl = 4'd3; rom_in = 1'b1; end
                8'h9A:        begin rom_ctl = 4'd4; rom_in = 1'b1; end
                8'hFF: if (modrm[5:3] == 3'b010) begin rom_ctl = 4'd5; rom_in = 1'b1; end
                8'hCF:        begin rom_ctl = 4'd7; rom_in = 1'b1; end
                8'hA5:        begin rom_ctl = 4'd8; rom_in = 1'b1; end
                default: ;
            endcase
        end
        is_hlt = !two_byte && op0 == 8'hF4;

        issue = state == ST_RUN && fetch_valid && len <= fetch_count && !flush &&
                (!s0_valid || s0_ready);
    end

    assign fetch_consume     = issue;
    assign fetch_consume_len = issue ? len[3:0] : 4'd0;

    // State, PC and stage-0 output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= ST_RUN;
            pc                    <= RESET_PC;
            halted                <= 1'b0;
            s0_valid              <= 1'b0;
            s0_displace_n_imm     <= '0;
            s0_addressing         <= '0;
            s0_addressing_bytes   <= '0;
            s0_displacement_bytes <= '0;
            s0_opcode             <= '0;
            s0_opcode_bytes       <= '0;
            s0_immediete_bytes    <= '0;
            s0_prefix             <= '0;
            s0_prefix_bytes       <= '0;
            s0_rom_control        <= '0;
            s0_rom_in_control     <= 1'b0;
            s0_pc                 <= '0;
            s0_branch_taken       <= 1'b0;
            s0_size_override      <= 1'b0;
        end else begin
            if (flush)         s0_valid <= 1'b0;
            else if (issue)    s0_valid <= 1'b1;
            else if (s0_ready) s0_valid <= 1'b0;

            if (issue) begin
                s0_displace_n_imm     <= dni;
                s0_addressing         <= {has_modrm ? modrm : 8'h00, has_sib ? sib : 8'h00};
                s0_addressing_bytes   <= addrb;
                s0_displacement_bytes <= 4'(disp);
                s0_opcode             <= {op0, op1};
                s0_opcode_bytes       <= opb;
                s0_immediete_bytes    <= 4'(imm);
                s0_prefix             <= prefix;
                s0_prefix_bytes       <= npfx;
                s0_rom_control        <= rom_ctl;
                s0_rom_in_control     <= rom_in;
                s0_pc                 <= pc;
                s0_branch_taken       <= fetch_branch_taken;
                s0_size_override      <= size_ovr;
            end

            if (write_eip)  pc <= IADDRW'(eip);
            else if (issue) pc <= pc + IADDRW'(len);

            case (state)
                ST_RUN: if (issue && is_hlt) begin
                    state  <= ST_HALTED;
                    halted <= 1'b1;
                end
                ST_HALTED: if (flush || write_eip) begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
                default: begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage_0.sv
// Directed bench for decode_stage_0 with hand-computed expectations.
module tb_decode_stage_0;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         write_eip;
    logic [31:0]  eip;
    logic         fetch_valid;
    logic [127:0] fetch_bytes;
    logic [4:0]   fetch_count;
    logic         fetch_branch_taken;
    logic         fetch_consume;
    logic [3:0]   fetch_consume_len;
    logic         halted;
    logic         s0_valid;
    logic         s0_ready;
    logic [63:0]  s0_displace_n_imm;
    logic [15:0]  s0_addressing;
    logic [1:0]   s0_addressing_bytes;
    logic [3:0]   s0_displacement_bytes;
    logic [15:0]  s0_opcode;
    logic [1:0]   s0_opcode_bytes;
    logic [3:0]   s0_immediete_bytes;
    logic [23:0]  s0_prefix;
    logic [1:0]   s0_prefix_bytes;
    logic [3:0]   s0_rom_control;
    logic         s0_rom_in_control;
    logic [31:0]  s0_pc;
    logic         s0_branch_taken;
    logic         s0_size_override;

    int vectors = 0;
    int miscompares = 0;

    decode_stage_0 #(.IADDRW(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .flush(flush), .write_eip(write_eip), .eip(eip),
        .fetch_valid(fetch_valid), .fetch_bytes(fetch_bytes), .fetch_count(fetch_count),
        .fetch_branch_taken(fetch_branch_taken), .fetch_consume(fetch_consume),
        .fetch_consume_len(fetch_consume_len), .halted(halted), .s0_valid(s0_valid),
        .s0_ready(s0_ready), .s0_displace_n_imm(s0_displace_n_imm),
        .s0_addressing(s0_addressing), .s0_addressing_bytes(s0_addressing_bytes),
        .s0_displacement_bytes(s0_displacement_bytes), .s0_opcode(s0_opcode),
        .s0_opcode_bytes(s0_opcode_bytes), .s0_immediete_bytes(s0_immediete_bytes),
        .s0_prefix(s0_prefix), .s0_prefix_bytes(s0_prefix_bytes),
        .s0_rom_control(s0_rom_control), .s0_rom_in_control(s0_rom_in_control),
        .s0_pc(s0_pc), .s0_branch_taken(s0_branch_taken), .s0_size_override(s0_size_override)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a window, check the same-cycle consume, then clock it in
    task automatic issue_one(input string tag, input logic [127:0] win, input logic [3:0] exp_len);
        fetch_bytes = win;
        fetch_count = 5'd16;
        fetch_valid = 1'b1;
        #1;
        check({tag, "_consume"}, fetch_consume, 1'b1);
        check({tag, "_len"}, fetch_consume_len, exp_len);
        cycle();
        fetch_valid = 1'b0;
        check({tag, "_valid"}, s0_valid, 1'b1);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; write_eip = 1'b0; eip = 32'h0;
        fetch_valid = 1'b0; fetch_bytes = '0; fetch_count = 5'd0;
        fetch_branch_taken = 1'b0; s0_ready = 1'b1;
        repeat (2) cycle();
        check("rst_valid", s0_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_pc", s0_pc, 32'h0);
        check("rst_opcode", s0_opcode, 16'h0);
        reset = 1'b0;
        cycle();

        // add eax, imm32
        issue_one("add", {40'h05_7856_3412, 88'h0}, 4'd5);
        check("add_opcode", s0_opcode, 16'h0500);
        check("add_opb", s0_opcode_bytes, 2'd1);
        check("add_imm", s0_immediete_bytes, 4'd4);
        check("add_dni", s0_displace_n_imm, 64'h7856_3412_0000_0000);
        check("add_pc", s0_pc, 32'h0);
        check("add_pfxb", s0_prefix_bytes, 2'd0);

        // operand-size prefix shrinks Z to 2
        issue_one("add16", {32'h66_05_3412, 96'h0}, 4'd4);
        check("add16_prefix", s0_prefix, 24'h660000);
        check("add16_pfxb", s0_prefix_bytes, 2'd1);
        check("add16_ovr", s0_size_override, 1'b1);
        check("add16_imm", s0_immediete_bytes, 4'd2);
        check("add16_dni", s0_displace_n_imm, 64'h3412_0000_0000_0000);
        check("add16_pc", s0_pc, 32'd5);

        // mov with SIB and disp32
        issue_one("sib", {56'h8B_848D_1000_0000, 72'h0}, 4'd7);
        check("sib_addr", s0_addressing, 16'h848D);
        check("sib_addrb", s0_addressing_bytes, 2'd2);
        check("sib_disp", s0_displacement_bytes, 4'd4);
        check("sib_dni", s0_displace_n_imm, 64'h1000_0000_0000_0000);
        check("sib_pc", s0_pc, 32'd9);
        check("sib_ovr", s0_size_override, 1'b0);

        // disp8 followed by imm32
        issue_one("movi", {56'hC7_45_08_EFBE_ADDE, 72'h0}, 4'd7);
        check("movi_dni", s0_displace_n_imm, 64'h08EF_BEAD_DE00_0000);
        check("movi_addr", s0_addressing, 16'h4500);
        check("movi_disp", s0_displacement_bytes, 4'd1);
        check("movi_imm", s0_immediete_bytes, 4'd4);
        check("movi_pc", s0_pc, 32'd16);

        // two-byte opcode with register ModRM
        issue_one("movzx", {24'h0F_B6_C0, 104'h0}, 4'd3);
        check("movzx_opcode", s0_opcode, 16'h0FB6);
        check("movzx_opb", s0_opcode_bytes, 2'd2);
        check("movzx_addrb", s0_addressing_bytes, 2'd1);
        check("movzx_pc", s0_pc, 32'd23);

        // backpressure: held instruction stays put, nothing consumed
        s0_ready = 1'b0;
        fetch_bytes = {8'h90, 120'h0};
        fetch_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_consume", fetch_consume, 1'b0);
            cycle();
            check("bp_valid", s0_valid, 1'b1);
            check("bp_opcode", s0_opcode, 16'h0FB6);
            check("bp_pc", s0_pc, 32'd23);
        end
        s0_ready = 1'b1;
        #1;
        check("bp_release_consume", fetch_consume, 1'b1);
        check("bp_release_len", fetch_consume_len, 4'd1);
        cycle();
        fetch_valid = 1'b0;
        check("nop_opcode", s0_opcode, 16'h9000);
        check("nop_pc", s0_pc, 32'd26);

        // short window stalls, then issues once complete
        fetch_bytes = {24'hE8_7856, 104'h0};
        fetch_count = 5'd3;
        fetch_valid = 1'b1;
        #1;
        check("stall_consume", fetch_consume, 1'b0);
        cycle();
        check("stall_valid", s0_valid, 1'b0);
        fetch_bytes = {40'hE8_7856_3412, 88'h0};
        fetch_count = 5'd5;
        #1;
        check("call_consume", fetch_consume, 1'b1);
        check("call_len", fetch_consume_len, 4'd5);
        cycle();
        fetch_valid = 1'b0;
        check("call_rom", s0_rom_control, 4'd3);
        check("call_rom_in", s0_rom_in_control, 1'b1);
        check("call_pc", s0_pc, 32'd27);

        // three prefixes recognised, fourth prefix-valued byte is the opcode
        issue_one("pfx3", {32'hF3_66_2E_3E, 96'h0}, 4'd4);
        check("pfx3_prefix", s0_prefix, 24'hF3662E);
        check("pfx3_pfxb", s0_prefix_bytes, 2'd3);
        check("pfx3_opcode", s0_opcode, 16'h3E00);
        check("pfx3_rom_in", s0_rom_in_control, 1'b0);

        // indirect call through ROM
        issue_one("callind", {16'hFF_D0, 112'h0}, 4'd2);
        check("callind_rom", s0_rom_control, 4'd5);
        check("callind_pc", s0_pc, 32'd36);

        // HLT issues then stops decode
        fetch_branch_taken = 1'b1;
        issue_one("hlt", {8'hF4, 120'h0}, 4'd1);
        fetch_branch_taken = 1'b0;
        check("hlt_halted", halted, 1'b1);
        check("hlt_taken", s0_branch_taken, 1'b1);
        check("hlt_pc", s0_pc, 32'd38);
        fetch_bytes = {8'h90, 120'h0};
        fetch_valid = 1'b1;
        #1;
        check("halted_consume", fetch_consume, 1'b0);
        cycle();
        check("halted_still", halted, 1'b1);

        // flush plus redirect leaves HALTED and reloads PC
        flush = 1'b1; write_eip = 1'b1; eip = 32'h100;
        #1;
        check("flush_consume", fetch_consume, 1'b0);
        cycle();
        flush = 1'b0; write_eip = 1'b0;
        check("flush_valid", s0_valid, 1'b0);
        check("flush_halted", halted, 1'b0);
        issue_one("redir", {8'h90, 120'h0}, 4'd1);
        check("redir_pc", s0_pc, 32'h100);

        // reset mid-operation drops held state
        s0_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_valid", s0_valid, 1'b0);
        check("midrst_pc", s0_pc, 32'h0);
        cycle();
        reset = 1'b0;
        s0_ready = 1'b1;
        issue_one("post_rst", {8'hC3, 120'h0}, 4'd1);
        check("post_rst_pc", s0_pc, 32'h0);
        check("post_rst_rom", s0_rom_control, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
